// File: rtl/pipe_ctrl_unit.sv
// Main control for the 5-stage RV32I pipeline: opcode decode, ID/EX/MEM/WB control
// word and rd carry, load-use bubbles, branch flushes, memory-busy freeze, perf counters.
module pipe_ctrl_unit #(
  parameter int REG_AW    = 5,
  parameter int EXT_OPS   = 1,
  parameter int HAZARD_EN = 1,
  parameter int CNT_W     = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              id_valid,
  input  logic [6:0]        id_opcode,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              ex_taken,
  input  logic              mem_busy,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              id_illegal,
  output logic [9:0]        ex_ctrl,
  output logic [REG_AW-1:0] ex_rd,
  output logic [9:0]        mem_ctrl,
  output logic [REG_AW-1:0] mem_rd,
  output logic [9:0]        wb_ctrl,
  output logic [REG_AW-1:0] wb_rd,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // Returns {legal, control_word}; unknown opcodes yield an all-zero word.
  function automatic logic [10:0] decode_op(input logic [6:0] op);
    logic [10:0] r;
    r = 11'h000;
    case (op)
      7'b0110011: r = {1'b1, 10'h022};
      7'b0010011: r = {1'b1, 10'h123};
      7'b0000011: r = {1'b1, 10'h170};
      7'b0100011: r = {1'b1, 10'h108};
      7'b1100011: r = {1'b1, 10'h005};
      7'b1101111: if (EXT_OPS != 0) r = {1'b1, 10'h2A0};
      7'b1100111: if (EXT_OPS != 0) r = {1'b1, 10'h3A0};
      default:    r = 11'h000;
    endcase
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic [10:0]       dec_p0;
  logic [9:0]        word_p0;
  logic              load_use;
  logic              idex_bubble;

  logic [9:0]        ctrl_p1, ctrl_p2, ctrl_p3;
  logic [REG_AW-1:0] rd_p1, rd_p2, rd_p3;
  logic [CNT_W-1:0]  stall_q, flush_q;

  // ID stage: decode and hazard detection
  always_comb begin
    dec_p0     = decode_op(id_opcode);
    word_p0    = id_valid ? dec_p0[9:0] : 10'h000;
    id_illegal = id_valid & ~dec_p0[10];
    load_use   = (HAZARD_EN != 0) & id_valid & ctrl_p1[4] & (rd_p1 != '0) &
                 ((rd_p1 == id_rs1) | (rd_p1 == id_rs2));
  end

  // Freeze dominates, then flush, then load-use stall.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (mem_busy) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else if (ex_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (load_use) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  // ID/EX, EX/MEM, MEM/WB registers and counters
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ctrl_p1 <= '0;
      ctrl_p2 <= '0;
      ctrl_p3 <= '0;
      rd_p1   <= '0;
      rd_p2   <= '0;
      rd_p3   <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else if (!mem_busy) begin
      ctrl_p1 <= idex_bubble ? 10'h000 : word_p0;
      rd_p1   <= idex_bubble ? '0 : id_rd;
      ctrl_p2 <= ctrl_p1;
      rd_p2   <= rd_p1;
      ctrl_p3 <= ctrl_p2;
      rd_p3   <= rd_p2;
      if (ex_taken)      flush_q <= sat_inc(flush_q);
      else if (load_use) stall_q <= sat_inc(stall_q);
    end
  end

  assign ex_ctrl   = ctrl_p1;
  assign ex_rd     = rd_p1;
  assign mem_ctrl  = ctrl_p2;
  assign mem_rd    = rd_p2;
  assign wb_ctrl   = ctrl_p3;
  assign wb_rd     = rd_p3;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: default instance plus an EXT_OPS=0, CNT_W=2 instance
// sharing the same stimulus.
module tb_pipe_ctrl_unit;

  logic       CLK = 1'b0;
  logic       RST;
  logic       id_valid;
  logic [6:0] id_opcode;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       ex_taken, mem_busy;

  logic       pc_write, ifid_write, ifid_flush, id_illegal;
  logic [9:0] ex_ctrl, mem_ctrl, wb_ctrl;
  logic [4:0] ex_rd, mem_rd, wb_rd;
  logic [15:0] stall_cnt, flush_cnt;

  logic       pc_write2, ifid_write2, ifid_flush2, id_illegal2;
  logic [9:0] ex_ctrl2, mem_ctrl2, wb_ctrl2;
  logic [4:0] ex_rd2, mem_rd2, wb_rd2;
  logic [1:0] stall_cnt2, flush_cnt2;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  pipe_ctrl_unit dut (
    .CLK(CLK), .RST(RST), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_taken(ex_taken),
    .mem_busy(mem_busy), .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .id_illegal(id_illegal), .ex_ctrl(ex_ctrl),
    .ex_rd(ex_rd), .mem_ctrl(mem_ctrl), .mem_rd(mem_rd), .wb_ctrl(wb_ctrl),
    .wb_rd(wb_rd), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_ctrl_unit #(.EXT_OPS(0), .CNT_W(2)) dut2 (
    .CLK(CLK), .RST(RST), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_taken(ex_taken),
    .mem_busy(mem_busy), .pc_write(pc_write2), .ifid_write(ifid_write2),
    .ifid_flush(ifid_flush2), .id_illegal(id_illegal2), .ex_ctrl(ex_ctrl2),
    .ex_rd(ex_rd2), .mem_ctrl(mem_ctrl2), .mem_rd(mem_rd2), .wb_ctrl(wb_ctrl2),
    .wb_rd(wb_rd2), .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [6:0] op, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd);
    id_valid  = v;
    id_opcode = op;
    id_rs1    = rs1;
    id_rs2    = rs2;
    id_rd     = rd;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1;
    ex_taken = 1'b0;
    mem_busy = 1'b0;
    drive(1'b0, 7'h00, 5'd0, 5'd0, 5'd0);
    tick();
    RST = 1'b0;
    #1;
    chk("rst_ex_ctrl", ex_ctrl, 10'h000);
    chk("rst_wb_ctrl", wb_ctrl, 10'h000);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_flush", flush_cnt, 0);
    chk("rst_pc_write", pc_write, 1);
    chk("rst_ifid_flush", ifid_flush, 0);

    // Basic instruction stream
    drive(1'b1, 7'h33, 5'd2, 5'd3, 5'd1); tick();
    chk("seq_add_ex", ex_ctrl, 10'h022);
    chk("seq_add_rd", ex_rd, 5'd1);
    drive(1'b1, 7'h13, 5'd1, 5'd0, 5'd2); tick();
    chk("seq_addi_ex", ex_ctrl, 10'h123);
    chk("seq_add_mem", mem_ctrl, 10'h022);
    drive(1'b1, 7'h03, 5'd0, 5'd0, 5'd3); tick();
    chk("seq_lw_ex", ex_ctrl, 10'h170);
    chk("seq_add_wb", wb_ctrl, 10'h022);
    chk("seq_add_wb_rd", wb_rd, 5'd1);
    drive(1'b1, 7'h23, 5'd1, 5'd2, 5'd0); tick();
    chk("seq_sw_ex", ex_ctrl, 10'h108);
    chk("seq_addi_wb", wb_ctrl, 10'h123);
    drive(1'b1, 7'h63, 5'd1, 5'd2, 5'd0); tick();
    chk("seq_beq_ex", ex_ctrl, 10'h005);
    chk("seq_lw_wb", wb_ctrl, 10'h170);
    drive(1'b0, 7'h00, 5'd0, 5'd0, 5'd0); tick();
    chk("seq_idle_ex", ex_ctrl, 10'h000);
    chk("seq_sw_wb", wb_ctrl, 10'h108);
    tick();
    chk("seq_beq_wb", wb_ctrl, 10'h005);

    // Load-use stall
    drive(1'b1, 7'h03, 5'd1, 5'd0, 5'd5); tick();
    drive(1'b1, 7'h33, 5'd5, 5'd6, 5'd7); #1;
    chk("lu_pc_write", pc_write, 0);
    chk("lu_ifid_write", ifid_write, 0);
    tick();
    chk("lu_bubble", ex_ctrl, 10'h000);
    chk("lu_stall_cnt", stall_cnt, 1);
    #1;
    chk("lu_resume_pc", pc_write, 1);
    tick();
    chk("lu_add_ex", ex_ctrl, 10'h022);
    chk("lu_add_rd", ex_rd, 5'd7);
    drive(1'b1, 7'h03, 5'd1, 5'd0, 5'd0); tick();
    drive(1'b1, 7'h33, 5'd0, 5'd6, 5'd7); #1;
    chk("x0_pc_write", pc_write, 1);
    tick();
    chk("x0_add_ex", ex_ctrl, 10'h022);
    chk("x0_stall_cnt", stall_cnt, 1);

    // Flush beats stall
    drive(1'b1, 7'h03, 5'd1, 5'd0, 5'd5); tick();
    drive(1'b1, 7'h33, 5'd5, 5'd6, 5'd7); ex_taken = 1'b1; #1;
    chk("fl_ifid_flush", ifid_flush, 1);
    chk("fl_pc_write", pc_write, 1);
    tick();
    ex_taken = 1'b0;
    chk("fl_ex_ctrl", ex_ctrl, 10'h000);
    chk("fl_flush_cnt", flush_cnt, 1);
    chk("fl_stall_cnt", stall_cnt, 1);

    // Memory-busy freeze
    drive(1'b1, 7'h33, 5'd2, 5'd3, 5'd1); tick();
    drive(1'b1, 7'h13, 5'd1, 5'd0, 5'd2); tick();
    chk("fz_pre_ex", ex_ctrl, 10'h123);
    chk("fz_pre_mem", mem_ctrl, 10'h022);
    drive(1'b1, 7'h03, 5'd0, 5'd0, 5'd9);
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("fz_pc_write", pc_write, 0);
      tick();
      chk("fz_ex", ex_ctrl, 10'h123);
      chk("fz_mem", mem_ctrl, 10'h022);
      chk("fz_wb", wb_ctrl, 10'h000);
      chk("fz_stall", stall_cnt, 1);
    end
    mem_busy = 1'b0;
    tick();
    chk("fz_post_ex", ex_ctrl, 10'h170);
    chk("fz_post_mem", mem_ctrl, 10'h123);
    chk("fz_post_wb", wb_ctrl, 10'h022);

    // Extended opcodes and illegal decode
    drive(1'b1, 7'h6F, 5'd0, 5'd0, 5'd1); #1;
    chk("jal_illegal", id_illegal, 0);
    chk("jal_illegal_noext", id_illegal2, 1);
    tick();
    chk("jal_ex", ex_ctrl, 10'h2A0);
    chk("jal_ex_noext", ex_ctrl2, 10'h000);
    drive(1'b1, 7'h67, 5'd0, 5'd0, 5'd1); tick();
    chk("jalr_ex", ex_ctrl, 10'h3A0);
    drive(1'b1, 7'h7F, 5'd0, 5'd0, 5'd1); #1;
    chk("ill_7f", id_illegal, 1);
    chk("ill_7f_noext", id_illegal2, 1);
    tick();
    chk("ill_ex", ex_ctrl, 10'h000);
    drive(1'b0, 7'h33, 5'd0, 5'd0, 5'd1); #1;
    chk("novalid_illegal", id_illegal, 0);
    tick();
    chk("novalid_ex", ex_ctrl, 10'h000);

    // Asynchronous reset in the middle of a stall
    drive(1'b1, 7'h03, 5'd1, 5'd0, 5'd5); tick();
    drive(1'b1, 7'h33, 5'd5, 5'd6, 5'd7); #3;
    chk("ar_pre_pc", pc_write, 0);
    RST = 1'b1; #1;
    chk("ar_ex_ctrl", ex_ctrl, 10'h000);
    chk("ar_ex_rd", ex_rd, 5'd0);
    chk("ar_mem_ctrl", mem_ctrl, 10'h000);
    chk("ar_stall", stall_cnt, 0);
    chk("ar_flush", flush_cnt, 0);
    chk("ar_pc_write", pc_write, 1);
    #1;
    RST = 1'b0;

    // Counter saturation on the narrow instance
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 7'h03, 5'd1, 5'd0, 5'd5); tick();
      drive(1'b1, 7'h33, 5'd5, 5'd6, 5'd7); tick();
    end
    chk("sat_stall_wide", stall_cnt, 5);
    chk("sat_stall_narrow", stall_cnt2, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
